// File: rtl/if_id_stage.sv
// ----------------------------------------------------------------------------
// if_id_stage
//
// IF/ID pipeline boundary of the 32-bit MIPS core. It sits between Fetch and
// Decode/Execute.
//
// Each fetched instruction and its PC+4 are captured in a 2-entry skid buffer.
// The head entry is presented to Decode with its fields already split out.
// The stage also does three control jobs:
//   - it detects load-use hazards against the instruction in ID/EX,
//   - it discards wrong-path instructions when a flush arrives,
//   - it drives PCWrite back to Fetch, which holds its PC while the buffer is
//     full.
//
// Optional build macro:
//   IFID_PERF_CNT_EN - adds the saturating performance counters stall_cnt,
//                      hazard_cnt and flush_cnt.
//
// Ports:
//   clk            core clock, rising edge
//   reset          asynchronous, active-low reset
//   in_valid       Fetch presents a valid instruction
//   in_inst        fetched instruction
//   in_pc4         PC+4 of that instruction
//   in_ready       buffer can accept a push this cycle
//   PCWrite        PC update enable to Fetch (same as in_ready)
//   flush          taken branch/jump resolved; drop everything held/arriving
//   idex_mem_read  instruction in ID/EX is a load
//   idex_rt        destination register of that load
//   out_ready      Decode can accept the head entry
//   out_valid      head entry valid
//   out_inst       head instruction (NOP_INST when empty)
//   out_pc4        head PC+4 (0 when empty)
//   out_opcode/out_rs/out_rt/out_rd/out_funct/out_imm
//                  field slices of out_inst
//   bubble         Decode must insert a NOP into ID/EX this cycle
//   stall_cnt/hazard_cnt/flush_cnt (IFID_PERF_CNT_EN only)
//                  saturating event counters
// ----------------------------------------------------------------------------
module if_id_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000000,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_inst,
  input  logic [XLEN-1:0]  in_pc4,
  output logic             in_ready,
  output logic             PCWrite,
  input  logic             flush,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_inst,
  output logic [XLEN-1:0]  out_pc4,
  output logic [5:0]       out_opcode,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [5:0]       out_funct,
  output logic [15:0]      out_imm,
`ifdef IFID_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             bubble
);

  localparam int DEPTH = 2;

  // --------------------------------------------------------------------------
  // Storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] instMem [DEPTH];
  logic [XLEN-1:0] pc4Mem  [DEPTH];

  logic       headPtrReg;
  logic       tailPtrReg;
  logic [1:0] countReg;
  logic [1:0] countNext;

  logic isFull;
  logic isEmpty;
  logic hazard;
  logic push;
  logic pop;

  assign isFull  = (countReg == 2'd2);
  assign isEmpty = (countReg == 2'd0);

  // Gating with reset makes the outputs drop the moment reset asserts. The
  // asynchronous clear of countReg does the same, so this is belt and braces.
  assign in_ready  = reset & ~isFull;
  assign PCWrite   = in_ready;
  assign out_valid = reset & ~isEmpty;

  // The head is read straight from the storage registers. Nothing in the input
  // path reaches out_* without first passing through a clock edge.
  assign out_inst = out_valid ? instMem[headPtrReg] : NOP_INST;
  assign out_pc4  = out_valid ? pc4Mem[headPtrReg]  : '0;

  // The field outputs are pure slices, so an empty buffer decodes as the NOP.
  assign out_opcode = out_inst[31:26];
  assign out_rs     = out_inst[25:21];
  assign out_rt     = out_inst[20:16];
  assign out_rd     = out_inst[15:11];
  assign out_funct  = out_inst[5:0];
  assign out_imm    = out_inst[15:0];

  // --------------------------------------------------------------------------
  // Load-use hazard
  // --------------------------------------------------------------------------
  // $0 can never carry a dependency, so a load into $0 does not stall.
  assign hazard = out_valid & idex_mem_read & (idex_rt != 5'd0) &
                  ((idex_rt == out_rs) | (idex_rt == out_rt));
  assign bubble = hazard;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  // A flush kills both directions. The same-cycle push is dropped, and no pop
  // is reported, because the head is wrong-path as well.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~hazard & ~flush;

  always_comb begin
    countNext = countReg;
    unique case ({push, pop})
      2'b10:   countNext = countReg + 2'd1;
      2'b01:   countNext = countReg - 2'd1;
      default: countNext = countReg;  // idle, or push+pop (net zero)
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      countReg   <= 2'd0;
      headPtrReg <= 1'b0;
      tailPtrReg <= 1'b0;
    end else if (flush) begin
      countReg   <= 2'd0;
      headPtrReg <= 1'b0;
      tailPtrReg <= 1'b0;
    end else begin
      countReg <= countNext;
      // With a depth of two, pointer wrap is a single-bit toggle.
      if (push) tailPtrReg <= ~tailPtrReg;
      if (pop)  headPtrReg <= ~headPtrReg;
    end
  end

  // --------------------------------------------------------------------------
  // Entry registers: one writer per slot, selected by the tail pointer.
  // On push+pop the new entry lands in the other slot, behind the old head.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          instMem[gi] <= '0;
          pc4Mem[gi]  <= '0;
        end else if (push && (tailPtrReg == 1'(gi))) begin
          instMem[gi] <= in_inst;
          pc4Mem[gi]  <= in_pc4;
        end
      end
    end
  endgenerate

`ifdef IFID_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters (saturating at all-ones)
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] stallCntReg;
  logic [CNT_W-1:0] hazardCntReg;
  logic [CNT_W-1:0] flushCntReg;

  logic stallEvent;
  logic flushEvent;

  assign stallEvent = in_valid & ~in_ready;
  // Only flushes that actually discard something are counted: either held
  // entries, or an instruction that would otherwise have been pushed.
  assign flushEvent = flush & (~isEmpty | (in_valid & in_ready));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCntReg  <= '0;
      hazardCntReg <= '0;
      flushCntReg  <= '0;
    end else begin
      if (stallEvent && (stallCntReg != '1))
        stallCntReg <= stallCntReg + CNT_W'(1);
      if (hazard && (hazardCntReg != '1))
        hazardCntReg <= hazardCntReg + CNT_W'(1);
      if (flushEvent && (flushCntReg != '1))
        flushCntReg <= flushCntReg + CNT_W'(1);
    end
  end

  assign stall_cnt  = stallCntReg;
  assign hazard_cnt = hazardCntReg;
  assign flush_cnt  = flushCntReg;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  localparam int XLEN = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [XLEN-1:0]  in_inst;
  logic [XLEN-1:0]  in_pc4;
  logic             in_ready;
  logic             PCWrite;
  logic             flush;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic             out_ready;
  logic             out_valid;
  logic [XLEN-1:0]  out_inst;
  logic [XLEN-1:0]  out_pc4;
  logic [5:0]       out_opcode;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [5:0]       out_funct;
  logic [15:0]      out_imm;
  logic             bubble;
`ifdef IFID_PERF_CNT_EN
  logic [15:0]      stall_cnt;
  logic [15:0]      hazard_cnt;
  logic [15:0]      flush_cnt;
`endif

  if_id_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_inst       (in_inst),
    .in_pc4        (in_pc4),
    .in_ready      (in_ready),
    .PCWrite       (PCWrite),
    .flush         (flush),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc4       (out_pc4),
    .out_opcode    (out_opcode),
    .out_rs        (out_rs),
    .out_rt        (out_rt),
    .out_rd        (out_rd),
    .out_funct     (out_funct),
    .out_imm       (out_imm),
`ifdef IFID_PERF_CNT_EN
    .stall_cnt     (stall_cnt),
    .hazard_cnt    (hazard_cnt),
    .flush_cnt     (flush_cnt),
`endif
    .bubble        (bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } entry_t;

  entry_t sb[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] INST_A = 32'h20080005;  // addi $8,$0,5
  localparam logic [31:0] INST_B = 32'h20090003;  // addi $9,$0,3
  localparam logic [31:0] INST_C = 32'h01095020;  // add  $10,$8,$9
  localparam logic [31:0] INST_D = 32'h8d2b0000;  // lw   $11,0($9)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic expHazard();
    logic [31:0] hd;
    if (sb.size() == 0) return 1'b0;
    hd = sb[0].inst;
    return idex_mem_read && (idex_rt != 5'd0) &&
           ((idex_rt == hd[25:21]) || (idex_rt == hd[20:16]));
  endfunction

  // Compare the DUT's combinational view with the scoreboard head.
  task automatic checkModel();
    logic [31:0] ei;
    logic [31:0] ep;
    ei = (sb.size() != 0) ? sb[0].inst : 32'h0;
    ep = (sb.size() != 0) ? sb[0].pc4  : 32'h0;
    chk("in_ready",  in_ready,  sb.size() != 2);
    chk("PCWrite",   PCWrite,   sb.size() != 2);
    chk("out_valid", out_valid, sb.size() != 0);
    chk("out_inst",  out_inst,  ei);
    chk("out_pc4",   out_pc4,   ep);
    chk("out_rs",    out_rs,    ei[25:21]);
    chk("out_rt",    out_rt,    ei[20:16]);
    chk("out_imm",   out_imm,   ei[15:0]);
    chk("bubble",    bubble,    expHazard());
  endtask

  // Drive one cycle's inputs on the falling edge, then check outputs.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc4,
                       input logic ordy, input logic fl, input logic mr, input logic [4:0] rt);
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc4 = pc4;
    out_ready = ordy; flush = fl; idex_mem_read = mr; idex_rt = rt;
    #1;
    checkModel();
  endtask

  // Update the scoreboard for the upcoming edge, then take that edge.
  task automatic commit();
    logic doPush;
    logic doPop;
    entry_t e;
    doPush = in_valid && (sb.size() != 2) && !flush;
    doPop  = (sb.size() != 0) && out_ready && !expHazard() && !flush;
    if (flush) sb.delete();
    else begin
      if (doPop) void'(sb.pop_front());
      if (doPush) begin
        e.inst = in_inst; e.pc4 = in_pc4;
        sb.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc4 = '0;
    flush = 1'b0; idex_mem_read = 1'b0; idex_rt = '0; out_ready = 1'b0;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_inst",  out_inst,  32'h0);
    chk("rst_PCWrite",   PCWrite,   1'b0);
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_bubble",    bubble,    1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_PCWrite",  PCWrite,  1'b1);
    $display("step reset: released");

    // Streaming: one instruction per cycle, Decode always ready
    drive(1, INST_A, 32'd4,  1, 0, 0, 0); commit();
    drive(1, INST_B, 32'd8,  1, 0, 0, 0); commit();
    drive(1, INST_C, 32'd12, 1, 0, 0, 0); commit();
    drive(0, 32'h0,  32'd0,  1, 0, 0, 0);
    chk("C_opcode", out_opcode, 6'h00);
    chk("C_rs",     out_rs,     5'd8);
    chk("C_rt",     out_rt,     5'd9);
    chk("C_rd",     out_rd,     5'd10);
    chk("C_funct",  out_funct,  6'h20);
    commit();
    drive(0, 32'h0, 32'd0, 1, 0, 0, 0); commit();
    $display("step streaming: done");

    // Backpressure: only two entries are accepted
    drive(1, INST_A, 32'd4,  0, 0, 0, 0); commit();
    drive(1, INST_B, 32'd8,  0, 0, 0, 0); commit();
    drive(1, INST_C, 32'd12, 0, 0, 0, 0);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_PCWrite",  PCWrite,  1'b0);
    commit();
    drive(1, INST_D, 32'd16, 0, 0, 0, 0); commit();
    drive(0, 32'h0, 32'd0, 1, 0, 0, 0);
    chk("drain_first", out_pc4, 32'd4);
    commit();
    drive(0, 32'h0, 32'd0, 1, 0, 0, 0);
    chk("drain_second", out_pc4, 32'd8);
    commit();
    drive(0, 32'h0, 32'd0, 1, 0, 0, 0);
    chk("drain_empty", out_valid, 1'b0);
    commit();
    $display("step backpressure: done");

    // Load-use on the head; pushes continue meanwhile
    drive(1, INST_C, 32'd100, 0, 0, 0, 5'd0); commit();
    drive(1, INST_D, 32'd104, 1, 0, 1, 5'd9);
    chk("lu_bubble", bubble, 1'b1);
    commit();
    drive(0, 32'h0, 32'd0, 1, 0, 0, 5'd0);
    chk("lu_bubble_clear", bubble, 1'b0);
    chk("lu_head_held",    out_inst, INST_C);
    commit();
    drive(0, 32'h0, 32'd0, 1, 0, 0, 5'd0);
    chk("lu_next", out_pc4, 32'd104);
    commit();
    drive(1, INST_C, 32'd108, 0, 0, 0, 5'd0); commit();
    drive(0, 32'h0, 32'd0, 1, 0, 1, 5'd0);
    chk("lu_rt0_nobubble", bubble, 1'b0);
    commit();
    drive(0, 32'h0, 32'd0, 1, 0, 1, 5'd8);  // load into $8 while head is gone
    commit();
    $display("step load-use: done");

    // Flush while full with an incoming instruction
    drive(1, INST_A, 32'd200, 0, 0, 0, 0); commit();
    drive(1, INST_B, 32'd204, 0, 0, 0, 0); commit();
    drive(1, INST_C, 32'd208, 1, 1, 1, 5'd8); commit();
    drive(0, 32'h0, 32'd0, 0, 0, 0, 0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready",  in_ready,  1'b1);
    commit();
    $display("step flush: done");

    // Asynchronous reset between edges while full
    drive(1, INST_A, 32'd300, 0, 0, 0, 0); commit();
    drive(1, INST_B, 32'd304, 0, 0, 1, 5'd8);
    chk("pre_rst_bubble", bubble, 1'b1);
    commit();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_inst",  out_inst,  32'h0);
    chk("arst_out_pc4",   out_pc4,   32'h0);
    chk("arst_in_ready",  in_ready,  1'b0);
    chk("arst_PCWrite",   PCWrite,   1'b0);
    chk("arst_bubble",    bubble,    1'b0);
`ifdef IFID_PERF_CNT_EN
    chk("arst_stall_cnt",  stall_cnt,  16'h0);
    chk("arst_hazard_cnt", hazard_cnt, 16'h0);
    chk("arst_flush_cnt",  flush_cnt,  16'h0);
`endif
    sb.delete();
    $display("step async reset: done");
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0; idex_mem_read = 1'b0;

    // Post-reset streaming sanity
    drive(1, INST_D, 32'd400, 1, 0, 0, 0); commit();
    drive(0, 32'h0,  32'd0,   1, 0, 0, 0); commit();
    drive(0, 32'h0,  32'd0,   1, 0, 0, 0); commit();
    $display("step post-reset: done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline boundary of the 32-bit MIPS core, directly downstream of Fetch and upstream of Decode/Execute.
- Captures each fetched instruction and its PC+4 (Fetch `ifOut`) in a 2-entry skid buffer.
- Presents the captured instruction to Decode with its fields split out.
- Detects load-use hazards against the ID/EX stage, discards wrong-path instructions on flush, and generates `PCWrite` back to Fetch.

Parameters:
- XLEN, 32, instruction/address width.
- NOP_INST, 32'h00000000, value driven on `out_inst` when no valid entry (sll $0,$0,0).
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  Fetch presents a valid instruction this cycle.
- in_inst  in  XLEN  fetched instruction (Fetch `inst`).
- in_pc4  in  XLEN  PC+4 of that instruction (Fetch `ifOut`).
- in_ready  out  1  buffer can accept a push this cycle.
- PCWrite  out  1  PC update enable to Fetch.
- flush  in  1  taken branch/jump resolved; discard everything held or arriving.
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rt  in  5  destination register of that load.
- out_ready  in  1  Decode can accept.
- out_valid  out  1  head entry valid.
- out_inst  out  XLEN  head instruction, NOP_INST when empty.
- out_pc4  out  XLEN  head PC+4, 0 when empty.
- out_opcode  out  6  out_inst[31:26].
- out_rs  out  5  out_inst[25:21].
- out_rt  out  5  out_inst[20:16].
- out_rd  out  5  out_inst[15:11].
- out_funct  out  6  out_inst[5:0].
- out_imm  out  16  out_inst[15:0].
- bubble  out  1  Decode must insert a NOP into ID/EX this cycle.

Behaviour:
- Storage: two entries {inst, pc4}, head/tail pointers, count 0..2.
- Reset (reset=0): count=0, pointers=0, all entries cleared. While reset is low: out_valid=0, out_inst=NOP_INST, out_pc4=0, bubble=0, PCWrite=0, in_ready=0. Reset takes effect immediately, including mid-operation.
- in_ready = reset & (count != 2).
- PCWrite = in_ready.
- hazard = out_valid & idex_mem_read & (idex_rt != 0) & ((idex_rt == out_rs) | (idex_rt == out_rt)). Combinational.
- bubble = hazard.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~hazard & ~flush.
- Latency: an instruction pushed at edge N is visible on out_* after edge N. There is no combinational in-to-out path.
- push only: write tail, count+1. pop only: advance head, count-1.
- push and pop together: count unchanged; new entry behind the old head.
- Full (count=2): in_ready=0 and PCWrite=0, so Fetch holds its PC. in_valid is ignored.
- Empty (count=0): out_valid=0, out_inst=NOP_INST, fields derive from NOP_INST, hazard=0.
- Hazard: head is held (no pop) and bubble=1 for exactly as long as the hazard condition holds (one cycle for a single load-use). Pushes may continue until full.
- Flush: at the next edge count=0 and pointers are reset. Any same-cycle push is dropped and no pop is counted. Flush overrides hazard and full.
- Pointers wrap modulo 2.
- Field outputs are pure slices of out_inst.

Optional Feature:
- IFID_PERF_CNT_EN defined: adds outputs stall_cnt, hazard_cnt, flush_cnt (each CNT_W bits).
  - stall_cnt increments each cycle with in_valid=1 and in_ready=0.
  - hazard_cnt increments each cycle with hazard=1.
  - flush_cnt increments on each flush cycle with count>0 or a pending push.
  - All counters saturate at all-ones and clear on reset.
- Not defined: these ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> out_valid=0, out_inst=32'h0, PCWrite=0, in_ready=0. Release -> in_ready=1 and PCWrite=1 in the same cycle.
- Streaming: in_valid=1 with pc4 = 4, 8, 12 and insts 0x20080005, 0x20090003, 0x01095020; out_ready=1 -> each appears on out_* one cycle after its push. For 0x01095020: out_rs=8, out_rt=9, out_rd=10, out_funct=0x20. count stays ≤1.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> two entries accepted, then in_ready=PCWrite=0. Raise out_ready -> entries pop in order pc4=4 then 8, with no loss or duplicate.
- Load-use: head 0x01095020; idex_mem_read=1, idex_rt=9 for one cycle -> bubble=1, head held. Next cycle bubble=0 and the pop occurs. With idex_rt=0 -> no bubble.
- Flush: count=2 with in_valid=1, pulse flush -> next cycle out_valid=0, count=0, and the incoming instruction is not stored.
- Async reset mid-stream: drop reset between clock edges while count=2 -> outputs clear immediately without a clock edge. With IFID_PERF_CNT_EN defined, all counters read 0.
